// File: rtl/gx4000_audio_dma.sv
// Plus/GX4000 three-channel sound DMA sequencer: per-scanline instruction fetch and PSG register writes.
// Optional macro GX4000_DMA_IRQ_EN enables the per-channel INT interrupt flags.
module gx4000_audio_dma (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        plus_mode,
    input  logic        hblank,
    input  logic        asic_en,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_data,
    input  logic        cpu_wr,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic [15:0] mem_data,
    input  logic        mem_ack,
    output logic [3:0]  psg_reg,
    output logic [7:0]  psg_data,
    output logic        psg_wr,
    input  logic        psg_ack,
    output logic [2:0]  dma_irq,
    output logic [7:0]  dcsr
);

    localparam int unsigned NCH = 3;
    localparam int unsigned AW  = 16;
    localparam int unsigned CW  = 12;
    localparam int unsigned PW  = 8;

    typedef enum logic [2:0] {S_IDLE, S_SEL, S_FETCH, S_EXEC, S_PSGWR} state_t;

    state_t        state_q, state_n;
    logic [1:0]    ch_q, ch_n;
    logic [AW-1:0] ptr_q [NCH], ptr_n [NCH];
    logic [AW-1:0] loop_addr_q [NCH], loop_addr_n [NCH];
    logic [PW-1:0] prescaler_q [NCH], prescaler_n [NCH];
    logic [PW-1:0] presc_q [NCH], presc_n [NCH];
    logic [CW-1:0] pause_q [NCH], pause_n [NCH];
    logic [CW-1:0] loop_q [NCH], loop_n [NCH];
    logic [NCH-1:0] enable_q, enable_n;
    logic [NCH-1:0] irq_q;
    logic          pending_q, pending_n;
    logic [15:0]   ir_q, ir_n;
    logic [AW-1:0] mem_addr_n;
    logic          mem_rd_n;
    logic [3:0]    psg_reg_n;
    logic [7:0]    psg_data_n;
    logic          psg_wr_n;
    logic          hb_q, hb_prev_q;
    logic          tick_c, cpu_we_c;

    assign tick_c   = hb_q & ~hb_prev_q & plus_mode;
    assign cpu_we_c = plus_mode & asic_en & cpu_wr;
    assign dma_irq  = irq_q;
    assign dcsr     = {1'b0, irq_q, 1'b0, enable_q};

    // Scanline tick edge detector on the registered hblank
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            hb_q      <= 1'b0;
            hb_prev_q <= 1'b0;
        end else begin
            hb_q      <= hblank;
            hb_prev_q <= hb_q;
        end
    end

`ifdef GX4000_DMA_IRQ_EN
    logic [NCH-1:0] irq_n;
    always_ff @(posedge clk_sys) begin
        if (reset) irq_q <= '0;
        else       irq_q <= irq_n;
    end
`else
    assign irq_q = '0;
`endif

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ch_q        <= '0;
            ptr_q       <= '{default: '0};
            loop_addr_q <= '{default: '0};
            prescaler_q <= '{default: '0};
            presc_q     <= '{default: '0};
            pause_q     <= '{default: '0};
            loop_q      <= '{default: '0};
            enable_q    <= '0;
            pending_q   <= 1'b0;
            ir_q        <= '0;
            mem_addr    <= '0;
            mem_rd      <= 1'b0;
            psg_reg     <= '0;
            psg_data    <= '0;
            psg_wr      <= 1'b0;
        end else begin
            state_q     <= state_n;
            ch_q        <= ch_n;
            ptr_q       <= ptr_n;
            loop_addr_q <= loop_addr_n;
            prescaler_q <= prescaler_n;
            presc_q     <= presc_n;
            pause_q     <= pause_n;
            loop_q      <= loop_n;
            enable_q    <= enable_n;
            pending_q   <= pending_n;
            ir_q        <= ir_n;
            mem_addr    <= mem_addr_n;
            mem_rd      <= mem_rd_n;
            psg_reg     <= psg_reg_n;
            psg_data    <= psg_data_n;
            psg_wr      <= psg_wr_n;
        end
    end

    always_comb begin
        logic       go_next;
        logic       start;
        logic [1:0] nc;
        state_n     = state_q;
        ch_n        = ch_q;
        ptr_n       = ptr_q;
        loop_addr_n = loop_addr_q;
        prescaler_n = prescaler_q;
        presc_n     = presc_q;
        pause_n     = pause_q;
        loop_n      = loop_q;
        enable_n    = enable_q;
        pending_n   = pending_q;
        ir_n        = ir_q;
        mem_addr_n  = mem_addr;
        mem_rd_n    = mem_rd;
        psg_reg_n   = psg_reg;
        psg_data_n  = psg_data;
        psg_wr_n    = psg_wr;
        go_next     = 1'b0;
        start       = 1'b0;
        nc          = 2'd0;
`ifdef GX4000_DMA_IRQ_EN
        // CPU clear is applied first so a same-cycle INT set wins
        irq_n = irq_q;
        if (cpu_we_c && cpu_addr == 16'h6C0F) irq_n = irq_q & ~cpu_data[6:4];
`endif

        if (tick_c && state_q != S_IDLE && !pending_q) pending_n = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (plus_mode && (tick_c || pending_q)) begin
                    start     = 1'b1;
                    pending_n = 1'b0;
                end
            end
            S_SEL: begin
                if (enable_q[ch_q] && pause_q[ch_q] != '0) begin
                    if (presc_q[ch_q] == '0) begin
                        presc_n[ch_q] = prescaler_q[ch_q];
                        pause_n[ch_q] = pause_q[ch_q] - CW'(1);
                    end else begin
                        presc_n[ch_q] = presc_q[ch_q] - PW'(1);
                    end
                end
                go_next = 1'b1;
            end
            S_FETCH: begin
                if (mem_ack) begin
                    ir_n     = mem_data;
                    mem_rd_n = 1'b0;
                    state_n  = S_EXEC;
                end
            end
            S_EXEC: begin
                go_next = 1'b1;
                case (ir_q[15:12])
                    4'h0: begin
                        psg_reg_n  = ir_q[11:8];
                        psg_data_n = ir_q[7:0];
                        psg_wr_n   = 1'b1;
                        state_n    = S_PSGWR;
                        go_next    = 1'b0;
                    end
                    4'h1: begin
                        pause_n[ch_q] = ir_q[11:0];
                        presc_n[ch_q] = prescaler_q[ch_q];
                    end
                    4'h2: begin
                        loop_n[ch_q]      = ir_q[11:0];
                        loop_addr_n[ch_q] = ptr_q[ch_q];
                    end
                    4'h4: begin
                        if (ir_q[0]) begin
                            if (loop_q[ch_q] > CW'(1)) begin
                                loop_n[ch_q] = loop_q[ch_q] - CW'(1);
                                ptr_n[ch_q]  = loop_addr_q[ch_q];
                            end else begin
                                loop_n[ch_q] = '0;
                            end
                        end
`ifdef GX4000_DMA_IRQ_EN
                        if (ir_q[4]) irq_n[ch_q] = 1'b1;
`endif
                        if (ir_q[5]) enable_n[ch_q] = 1'b0;
                    end
                    default: ;
                endcase
            end
            S_PSGWR: begin
                if (psg_ack) begin
                    psg_wr_n = 1'b0;
                    go_next  = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase

        // Advance to the next channel, or wrap to a pending tick, or fall idle
        if (go_next) begin
            if (!plus_mode) begin
                state_n = S_IDLE;
            end else if (ch_q == 2'd2) begin
                if (pending_q) begin
                    start     = 1'b1;
                    pending_n = 1'b0;
                end else begin
                    state_n = S_IDLE;
                end
            end else begin
                start = 1'b1;
                nc    = ch_q + 2'd1;
            end
        end

        // Pointer advances at fetch launch so later CPU writes land on the next fetch
        if (start) begin
            ch_n = nc;
            if (enable_q[nc] && pause_q[nc] == '0) begin
                state_n    = S_FETCH;
                mem_rd_n   = 1'b1;
                mem_addr_n = ptr_q[nc];
                ptr_n[nc]  = ptr_q[nc] + AW'(2);
            end else begin
                state_n = S_SEL;
            end
        end

        if (cpu_we_c) begin
            for (int c = 0; c < NCH; c++) begin
                if (cpu_addr == AW'(32'h6C00 + 4 * c)) ptr_n[c][7:0]  = {cpu_data[7:1], 1'b0};
                if (cpu_addr == AW'(32'h6C01 + 4 * c)) ptr_n[c][15:8] = cpu_data;
                if (cpu_addr == AW'(32'h6C02 + 4 * c)) prescaler_n[c] = cpu_data;
            end
            if (cpu_addr == 16'h6C0F) enable_n = cpu_data[2:0];
        end

        for (int c = 0; c < NCH; c++) begin
            if (enable_n[c] && !enable_q[c]) begin
                pause_n[c] = '0;
                loop_n[c]  = '0;
                presc_n[c] = '0;
            end
        end

        if (!plus_mode) pending_n = 1'b0;
    end

endmodule

// File: tb/tb_gx4000_audio_dma.sv
// Directed bench for gx4000_audio_dma: vector table of single instructions plus multi-tick sequences.
module tb_gx4000_audio_dma;

`ifdef GX4000_DMA_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        plus_mode = 1'b1;
    logic        hblank = 1'b0;
    logic        asic_en = 1'b1;
    logic [15:0] cpu_addr = '0;
    logic [7:0]  cpu_data = '0;
    logic        cpu_wr = 1'b0;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [15:0] mem_data;
    logic        mem_ack;
    logic [3:0]  psg_reg;
    logic [7:0]  psg_data;
    logic        psg_wr;
    logic        psg_ack;
    logic [2:0]  dma_irq;
    logic [7:0]  dcsr;

    gx4000_audio_dma dut (
        .clk_sys(clk_sys), .reset(reset), .plus_mode(plus_mode), .hblank(hblank),
        .asic_en(asic_en), .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_wr(cpu_wr),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ack(mem_ack),
        .psg_reg(psg_reg), .psg_data(psg_data), .psg_wr(psg_wr), .psg_ack(psg_ack),
        .dma_irq(dma_irq), .dcsr(dcsr)
    );

    always #5 clk_sys = ~clk_sys;

    // Memory and PSG responders with programmable latency
    logic [15:0] mem [256];
    int          mem_lat = 0;
    int          psg_lat = 0;
    bit          psg_hold = 1'b0;
    int          mcnt = 0;
    int          pcnt = 0;
    logic [15:0] fetch_log [$];
    logic [11:0] psg_log [$];

    assign mem_data = mem[mem_addr[8:1]];
    assign mem_ack  = mem_rd && (mcnt == mem_lat);
    assign psg_ack  = psg_wr && !psg_hold && (pcnt == psg_lat);

    always @(posedge clk_sys) begin
        if (mem_rd && mem_ack) fetch_log.push_back(mem_addr);
        if (psg_wr && psg_ack) psg_log.push_back({psg_reg, psg_data});
        mcnt <= (mem_rd && !mem_ack) ? mcnt + 1 : 0;
        pcnt <= (psg_wr && !psg_ack) ? pcnt + 1 : 0;
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic do_reset();
        @(negedge clk_sys);
        reset = 1'b1;
        cycles(2);
        reset = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem_lat = 0; psg_lat = 0; psg_hold = 1'b0;
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        cpu_addr = a; cpu_data = d; cpu_wr = 1'b1;
        @(negedge clk_sys);
        cpu_wr = 1'b0;
    endtask

    task automatic set_ptr(input int c, input logic [15:0] p);
        cpu_write(16'(16'h6C00 + 4 * c), p[7:0]);
        cpu_write(16'(16'h6C01 + 4 * c), p[15:8]);
    endtask

    task automatic tick();
        hblank = 1'b1;
        @(negedge clk_sys);
        hblank = 1'b0;
    endtask

    typedef struct {
        logic [15:0] ptr;
        logic [15:0] instr;
        int          exp_n;
        logic [11:0] exp_wr;
        logic [7:0]  exp_dcsr;
        logic [15:0] exp_addr;
    } vec_t;

    vec_t vecs [8];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int pb, fb;
        logic [15:0] w;
        vecs[0] = '{16'h4000, 16'h0712, 1, 12'h712, 8'h01, 16'h4000};
        vecs[1] = '{16'h4011, 16'h0FAB, 1, 12'hFAB, 8'h01, 16'h4010};
        vecs[2] = '{16'h4020, 16'h1000, 0, 12'h000, 8'h01, 16'h4020};
        vecs[3] = '{16'h4030, 16'h4020, 0, 12'h000, 8'h00, 16'h4030};
        vecs[4] = '{16'h4040, 16'h4030, 0, 12'h000, IRQ_EN ? 8'h10 : 8'h00, 16'h4040};
        vecs[5] = '{16'h4050, 16'h3ABC, 0, 12'h000, 8'h01, 16'h4050};
        vecs[6] = '{16'h4060, 16'h2005, 0, 12'h000, 8'h01, 16'h4060};
        vecs[7] = '{16'h4070, 16'h4001, 0, 12'h000, 8'h01, 16'h4070};

        // Reset values
        do_reset();
        check("rst_mem_addr", 32'(mem_addr), 32'h0);
        check("rst_mem_rd", 32'(mem_rd), 32'h0);
        check("rst_psg_wr", 32'(psg_wr), 32'h0);
        check("rst_psg_reg_data", 32'({psg_reg, psg_data}), 32'h0);
        check("rst_dma_irq", 32'(dma_irq), 32'h0);
        check("rst_dcsr", 32'(dcsr), 32'h0);

        // CPU writes ignored outside plus mode
        plus_mode = 1'b0;
        cpu_write(16'h6C0F, 8'h07);
        check("nonplus_write_ignored", 32'(dcsr), 32'h00);
        plus_mode = 1'b1;
        cpu_write(16'h6C0F, 8'h07);
        check("dcsr_enable_write", 32'(dcsr), 32'h07);

        // Single-instruction vectors
        for (int v = 0; v < 8; v++) begin
            do_reset();
            w = vecs[v].exp_addr;
            mem[w[8:1]] = vecs[v].instr;
            set_ptr(0, vecs[v].ptr);
            cpu_write(16'h6C0F, 8'h01);
            pb = psg_log.size();
            fb = fetch_log.size();
            tick();
            cycles(20);
            check($sformatf("vec%0d_nwrites", v), 32'(psg_log.size() - pb), 32'(vecs[v].exp_n));
            if (vecs[v].exp_n == 1)
                check($sformatf("vec%0d_write", v), psg_log.size() > pb ? 32'(psg_log[pb]) : 32'hDEAD, 32'(vecs[v].exp_wr));
            check($sformatf("vec%0d_fetch_addr", v), fetch_log.size() > fb ? 32'(fetch_log[fb]) : 32'hDEAD, 32'(vecs[v].exp_addr));
            check($sformatf("vec%0d_dcsr", v), 32'(dcsr), 32'(vecs[v].exp_dcsr));
        end

        // LOAD latency: mem_rd at N+1, psg_wr at N+3, then STOP on the next tick
        do_reset();
        mem[8'h00] = 16'h0712;
        mem[8'h01] = 16'h4020;
        set_ptr(0, 16'h4000);
        cpu_write(16'h6C0F, 8'h01);
        pb = psg_log.size();
        fb = fetch_log.size();
        hblank = 1'b1;
        @(negedge clk_sys);
        hblank = 1'b0;
        check("lat_mem_rd_at_N", 32'(mem_rd), 32'h0);
        @(negedge clk_sys);
        check("lat_mem_rd_at_N1", 32'(mem_rd), 32'h1);
        @(negedge clk_sys);
        check("lat_psg_wr_at_N2", 32'(psg_wr), 32'h0);
        @(negedge clk_sys);
        check("lat_psg_wr_at_N3", 32'(psg_wr), 32'h1);
        check("lat_psg_reg_data", 32'({psg_reg, psg_data}), 32'h712);
        cycles(15);
        tick();
        cycles(15);
        check("load_nwrites", 32'(psg_log.size() - pb), 32'd1);
        check("load_second_fetch", fetch_log.size() > fb + 1 ? 32'(fetch_log[fb + 1]) : 32'hDEAD, 32'h4002);
        check("load_stop_dcsr", 32'(dcsr), 32'h00);

        // PAUSE with prescaler 1: the write lands on tick 8
        do_reset();
        mem[8'h00] = 16'h1003;
        mem[8'h01] = 16'h0855;
        set_ptr(0, 16'h4000);
        cpu_write(16'h6C02, 8'h01);
        cpu_write(16'h6C0F, 8'h01);
        pb = psg_log.size();
        for (int t = 1; t <= 8; t++) begin
            tick();
            cycles(15);
            check($sformatf("pause_tick%0d_nwrites", t), 32'(psg_log.size() - pb), t == 8 ? 32'd1 : 32'd0);
        end
        check("pause_write", psg_log.size() > pb ? 32'(psg_log[pb]) : 32'hDEAD, 32'h855);

        // REPEAT 3 with slow memory
        do_reset();
        mem_lat = 2;
        mem[8'h00] = 16'h2003;
        mem[8'h01] = 16'h0101;
        mem[8'h02] = 16'h4001;
        mem[8'h03] = 16'h4020;
        set_ptr(0, 16'h4000);
        cpu_write(16'h6C0F, 8'h01);
        pb = psg_log.size();
        for (int t = 0; t < 10; t++) begin
            tick();
            cycles(15);
        end
        check("repeat_nwrites", 32'(psg_log.size() - pb), 32'd3);
        for (int i = 0; i < 3; i++)
            check($sformatf("repeat_write%0d", i), psg_log.size() > pb + i ? 32'(psg_log[pb + i]) : 32'hDEAD, 32'h101);
        check("repeat_stopped_dcsr", 32'(dcsr), 32'h00);

        // INT + STOP, then CPU clear
        do_reset();
        mem[8'h00] = 16'h4030;
        set_ptr(0, 16'h4000);
        cpu_write(16'h6C0F, 8'h01);
        tick();
        cycles(15);
        check("int_dma_irq", 32'(dma_irq), IRQ_EN ? 32'h1 : 32'h0);
        check("int_dcsr", 32'(dcsr), IRQ_EN ? 32'h10 : 32'h00);
        cpu_write(16'h6C0F, 8'h10);
        check("int_clear_dma_irq", 32'(dma_irq), 32'h0);
        check("int_clear_dcsr", 32'(dcsr), 32'h00);

        // Pointer wrap from 0xFFFE to 0x0000
        do_reset();
        mem[8'hFF] = 16'h0301;
        mem[8'h00] = 16'h0402;
        set_ptr(0, 16'hFFFE);
        cpu_write(16'h6C0F, 8'h01);
        pb = psg_log.size();
        fb = fetch_log.size();
        tick();
        cycles(15);
        tick();
        cycles(15);
        check("wrap_fetch0", fetch_log.size() > fb ? 32'(fetch_log[fb]) : 32'hDEAD, 32'hFFFE);
        check("wrap_fetch1", fetch_log.size() > fb + 1 ? 32'(fetch_log[fb + 1]) : 32'hDEAD, 32'h0000);
        check("wrap_write1", psg_log.size() > pb + 1 ? 32'(psg_log[pb + 1]) : 32'hDEAD, 32'h402);

        // Three channels, slow PSG, pending tick serviced, third tick dropped
        do_reset();
        psg_lat = 3;
        mem[8'h00] = 16'h0011; mem[8'h01] = 16'h0014; mem[8'h02] = 16'h0017;
        mem[8'h40] = 16'h0122; mem[8'h41] = 16'h0125; mem[8'h42] = 16'h0128;
        mem[8'h20] = 16'h0233; mem[8'h21] = 16'h0236; mem[8'h22] = 16'h0239;
        set_ptr(0, 16'h4000);
        set_ptr(1, 16'h4080);
        set_ptr(2, 16'h4040);
        cpu_write(16'h6C0F, 8'h07);
        pb = psg_log.size();
        tick();
        cycles(3);
        tick();
        cycles(3);
        tick();
        cycles(80);
        check("multi_nwrites", 32'(psg_log.size() - pb), 32'd6);
        begin
            logic [11:0] exp_seq [6];
            exp_seq = '{12'h011, 12'h122, 12'h233, 12'h014, 12'h125, 12'h236};
            for (int i = 0; i < 6; i++)
                check($sformatf("multi_write%0d", i), psg_log.size() > pb + i ? 32'(psg_log[pb + i]) : 32'hDEAD, 32'(exp_seq[i]));
        end

        // Reset while a PSG write awaits its ack
        do_reset();
        psg_hold = 1'b1;
        mem[8'h00] = 16'h0712;
        set_ptr(0, 16'h4000);
        cpu_write(16'h6C0F, 8'h01);
        tick();
        for (int i = 0; i < 20 && !psg_wr; i++) @(negedge clk_sys);
        check("rstmid_psg_wr_seen", 32'(psg_wr), 32'h1);
        reset = 1'b1;
        @(negedge clk_sys);
        check("rstmid_psg_wr", 32'(psg_wr), 32'h0);
        check("rstmid_mem_rd", 32'(mem_rd), 32'h0);
        check("rstmid_dcsr", 32'(dcsr), 32'h00);
        check("rstmid_psg_reg_data", 32'({psg_reg, psg_data}), 32'h0);
        reset = 1'b0;
        psg_hold = 1'b0;
        cycles(5);
        check("rstmid_idle_after", 32'({mem_rd, psg_wr}), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
